// File: rtl/burst_ram_pkg.sv
// Shared types and constants for the burst RAM arbiter.
// Holds the FSM state enum, default burst/spacing values and command encodings.
package burst_ram_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WRITE_BEATS,
        ST_READ_WAIT,
        ST_READ_BEATS
    } br_state_e;

    localparam int BURST_BEATS_DEF            = 4;
    localparam int COMMAND_DELAY_INTERVAL_DEF = 14;

    localparam logic BR_CMD_READ  = 1'b0;
    localparam logic BR_CMD_WRITE = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-port round-robin grant.
// Ports: req[1:0] requests, last_grant previous winner, grant winning port index.
module rr_arbiter2 (
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       grant
);

    // A tie (or no request) favours the port that did not win last time.
    always_comb begin
        grant = ~last_grant;
        if (req == 2'b01) begin
            grant = 1'b0;
        end else if (req == 2'b10) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/burst_ram_arbiter.sv
// Shares one burst RAM command/data interface between two requesters.
// Ports: rq_* requester side (cmd/addr/data/mask in, ready/read data out),
//        br_* memory IP side, timeout_err pulse on an aborted read.
module burst_ram_arbiter
    import burst_ram_pkg::*;
#(
    parameter int BURST_RAM_DEPTH_BITWIDTH = 21,
    parameter int COMMAND_DELAY_INTERVAL   = COMMAND_DELAY_INTERVAL_DEF,
    parameter int BURST_BEATS              = BURST_BEATS_DEF,
    parameter int READ_TIMEOUT             = 255
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [1:0]                          rq_cmd,
    input  logic [1:0]                          rq_cmd_en,
    input  logic [BURST_RAM_DEPTH_BITWIDTH-1:0] rq_addr [0:1],
    input  logic [63:0]                         rq_wr_data [0:1],
    input  logic [7:0]                          rq_data_mask [0:1],
    output logic [1:0]                          rq_cmd_ready,
    output logic [63:0]                         rq_rd_data,
    output logic [1:0]                          rq_rd_data_valid,
    output logic                                timeout_err,
    output logic                                br_cmd,
    output logic                                br_cmd_en,
    output logic [BURST_RAM_DEPTH_BITWIDTH-1:0] br_addr,
    output logic [63:0]                         br_wr_data,
    output logic [7:0]                          br_data_mask,
    input  logic [63:0]                         br_rd_data,
    input  logic                                br_rd_data_valid
);

    localparam int AW = BURST_RAM_DEPTH_BITWIDTH;

    br_state_e   state_q, state_d;
    logic [5:0]  delay_cnt_q, delay_cnt_d;
    logic [1:0]  beat_cnt_q, beat_cnt_d;
    logic [7:0]  tmo_cnt_q, tmo_cnt_d;
    logic        owner_q, owner_d;
    logic        last_grant_q, last_grant_d;
    logic        br_cmd_q, br_cmd_d;
    logic        br_cmd_en_q, br_cmd_en_d;
    logic [AW-1:0] br_addr_q, br_addr_d;
    logic [63:0] br_wr_data_q, br_wr_data_d;
    logic [7:0]  br_data_mask_q, br_data_mask_d;
    logic        timeout_err_q, timeout_err_d;

    logic grant;
    logic can_accept;
    logic accept;
    logic in_read;

    rr_arbiter2 u_arb (
        .req        (rq_cmd_en),
        .last_grant (last_grant_q),
        .grant      (grant)
    );

    always_comb begin
        can_accept = rst_n && (state_q == ST_IDLE) && (delay_cnt_q == 6'd0);
        rq_cmd_ready[0] = can_accept && !grant;
        rq_cmd_ready[1] = can_accept && grant;
        accept = |(rq_cmd_en & rq_cmd_ready);
    end

    // Read data is routed straight through; only the owner sees valid.
    always_comb begin
        in_read = (state_q == ST_READ_WAIT) || (state_q == ST_READ_BEATS);
        rq_rd_data = br_rd_data;
        rq_rd_data_valid[0] = br_rd_data_valid && in_read && !owner_q;
        rq_rd_data_valid[1] = br_rd_data_valid && in_read && owner_q;
    end

    always_comb begin
        state_d        = state_q;
        delay_cnt_d    = delay_cnt_q;
        beat_cnt_d     = beat_cnt_q;
        tmo_cnt_d      = tmo_cnt_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        br_cmd_d       = br_cmd_q;
        br_cmd_en_d    = 1'b0;
        br_addr_d      = br_addr_q;
        br_wr_data_d   = br_wr_data_q;
        br_data_mask_d = br_data_mask_q;
        timeout_err_d  = 1'b0;

        // Command spacing runs regardless of the transaction state.
        if (delay_cnt_q != 6'd0) begin
            delay_cnt_d = delay_cnt_q - 6'd1;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    br_cmd_d       = rq_cmd[grant];
                    br_addr_d      = rq_addr[grant];
                    br_wr_data_d   = rq_wr_data[grant];
                    br_data_mask_d = rq_data_mask[grant];
                    br_cmd_en_d    = 1'b1;
                    owner_d        = grant;
                    last_grant_d   = grant;
                    delay_cnt_d    = 6'(COMMAND_DELAY_INTERVAL - 1);
                    beat_cnt_d     = 2'd0;
                    tmo_cnt_d      = 8'd0;
                    if (rq_cmd[grant] == BR_CMD_WRITE) begin
                        state_d = ST_WRITE_BEATS;
                    end else begin
                        state_d = ST_READ_WAIT;
                    end
                end
            end
            ST_WRITE_BEATS: begin
                // Beat 0 went out with the command; this forwards 1..N-1.
                br_wr_data_d = rq_wr_data[owner_q];
                if (beat_cnt_q == 2'(BURST_BEATS - 2)) begin
                    state_d = ST_IDLE;
                end else begin
                    beat_cnt_d = beat_cnt_q + 2'd1;
                end
            end
            ST_READ_WAIT: begin
                if (br_rd_data_valid) begin
                    beat_cnt_d = 2'd1;
                    state_d    = ST_READ_BEATS;
                end else if (tmo_cnt_q == 8'(READ_TIMEOUT - 1)) begin
                    timeout_err_d = 1'b1;
                    state_d       = ST_IDLE;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 8'd1;
                end
            end
            ST_READ_BEATS: begin
                if (br_rd_data_valid) begin
                    if (beat_cnt_q == 2'(BURST_BEATS - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            delay_cnt_q    <= 6'd0;
            beat_cnt_q     <= 2'd0;
            tmo_cnt_q      <= 8'd0;
            owner_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            br_cmd_q       <= 1'b0;
            br_cmd_en_q    <= 1'b0;
            br_addr_q      <= '0;
            br_wr_data_q   <= 64'd0;
            br_data_mask_q <= 8'd0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            delay_cnt_q    <= delay_cnt_d;
            beat_cnt_q     <= beat_cnt_d;
            tmo_cnt_q      <= tmo_cnt_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            br_cmd_q       <= br_cmd_d;
            br_cmd_en_q    <= br_cmd_en_d;
            br_addr_q      <= br_addr_d;
            br_wr_data_q   <= br_wr_data_d;
            br_data_mask_q <= br_data_mask_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign br_cmd       = br_cmd_q;
    assign br_cmd_en    = br_cmd_en_q;
    assign br_addr      = br_addr_q;
    assign br_wr_data   = br_wr_data_q;
    assign br_data_mask = br_data_mask_q;
    assign timeout_err  = timeout_err_q;

endmodule
